// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK 2-D convolution over a raster-ordered N x N frame.
//
// Pixels arrive in raster order on i_x with a valid/ready handshake. K-1 line buffers
// (depth N) keep the previous rows, and a KxK window register shifts one column per
// accepted pixel. Row/col counters decide when a window is complete, including stride
// decimation. The datapath has two stages: registered products, then a registered sum.
// A frame-level FSM (IDLE/RUN/FLUSH) gates weight loading and drains the pipeline.
//
// Parameters:
//   KERNEL_SIZE  kernel edge K (>=2)
//   DATA_BW      pixel width, signed
//   WEIGHT_BW    weight width, signed
//   SUM_BW       accumulator / output width, signed, wraps modulo 2**SUM_BW
//   ADDR_BW      weight address width (2**ADDR_BW >= K*K)
//   DATA_SIZE    frame edge N (>=K)
//   STRIDE       window step in both axes (>=1)
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   i_w_en/i_addr/i_w  weight write port (index r*K+c), honoured only in IDLE
//   i_valid/o_ready/i_x  pixel input handshake
//   o_valid/i_ready/o_y  result output handshake
//   o_last          marks the final output of a frame
//
// Configuration macro:
//   CONV_RELU_EN    when defined, the stage-2 sum is clamped to 0 if negative.

module conv2d_stream #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_BW     = 8,
  parameter int unsigned WEIGHT_BW   = 8,
  parameter int unsigned SUM_BW      = 20,
  parameter int unsigned ADDR_BW     = 4,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned STRIDE      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_w_en,
  input  logic [ADDR_BW-1:0]   i_addr,
  input  logic [WEIGHT_BW-1:0] i_w,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_BW-1:0]   i_x,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SUM_BW-1:0]    o_y,
  output logic                 o_last
);

  localparam int unsigned K        = KERNEL_SIZE;
  localparam int unsigned KK       = K * K;
  localparam int unsigned N        = DATA_SIZE;
  localparam int unsigned CW       = $clog2(N);
  localparam int unsigned PW       = DATA_BW + WEIGHT_BW;
  localparam int unsigned OUT      = (N - K) / STRIDE + 1;
  // Bottom-right pixel of the last stride-aligned window; may be short of N-1.
  localparam int unsigned LAST_POS = (K - 1) + (OUT - 1) * STRIDE;

  localparam logic [CW-1:0] LastIdx = CW'(N - 1);
  localparam logic [CW-1:0] LastWin = CW'(LAST_POS);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e state_q, state_d;

  logic [CW-1:0] col_q, row_q;

  logic signed [WEIGHT_BW-1:0] w_q   [KK];
  logic signed [DATA_BW-1:0]   lb_q  [K-1][N];
  logic signed [DATA_BW-1:0]   win_q [KK];
  logic signed [DATA_BW-1:0]   win_d [KK];
  // Column entering the window: col_vec[0] is the current row, col_vec[j] is j rows up.
  logic signed [DATA_BW-1:0]   col_vec [K];

  logic signed [PW-1:0]     prod_q [KK];
  logic signed [PW-1:0]     prod_d [KK];
  logic signed [SUM_BW-1:0] sum_d;
  logic signed [SUM_BW-1:0] y_d, y_q;

  logic v1_q, last1_q, v2_q, last2_q;
  logic adv, accept;
  logic win_done, win_last, frame_end;

  // Handshake. A stall holds the output register, which freezes every upstream stage.
  assign adv     = !v2_q || i_ready;
  assign o_ready = !rst && adv && !i_w_en && (state_q != StFlush);
  assign accept  = i_valid && o_ready;

  // Window completion is judged on the coordinates of the pixel being accepted.
  assign win_done = (32'(row_q) >= K - 1) && (32'(col_q) >= K - 1) &&
                    (((32'(row_q) - (K - 1)) % STRIDE) == 0) &&
                    (((32'(col_q) - (K - 1)) % STRIDE) == 0);
  assign win_last  = (row_q == LastWin) && (col_q == LastWin);
  assign frame_end = (row_q == LastIdx) && (col_q == LastIdx);

  // Frame FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (accept && frame_end) state_d = StFlush;
      // Empty after this edge: stage 1 holds nothing and stage 2 is moving on.
      StFlush: if (adv && !v1_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Window next-state: shift left one column, new column enters on the right.
  always_comb begin
    col_vec[0] = i_x;
    for (int j = 1; j < K; j++) begin
      col_vec[j] = lb_q[j-1][col_q];
    end
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r*K + c] = win_q[r*K + c + 1];
      end
    end
    // Row 0 of the window is the oldest row.
    for (int r = 0; r < K; r++) begin
      win_d[r*K + K - 1] = col_vec[K - 1 - r];
    end
  end

  // Stage-1 products are taken from the window including the pixel being accepted.
  always_comb begin
    for (int i = 0; i < KK; i++) begin
      prod_d[i] = PW'(win_d[i]) * PW'(w_q[i]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < KK; i++) begin
      sum_d = sum_d + SUM_BW'(prod_q[i]);
    end
    y_d = sum_d;
`ifdef CONV_RELU_EN
    if (sum_d[SUM_BW-1]) begin
      y_d = '0;
    end
`endif
  end

  // Control: FSM, counters, weights, pipeline valid/last
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      for (int i = 0; i < KK; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      // Out-of-range addresses match no entry and are dropped.
      if (i_w_en && (state_q == StIdle)) begin
        for (int i = 0; i < KK; i++) begin
          if (i_addr == ADDR_BW'(i)) begin
            w_q[i] <= i_w;
          end
        end
      end

      if (accept) begin
        if (col_q == LastIdx) begin
          col_q <= '0;
          row_q <= (row_q == LastIdx) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      if (adv) begin
        v1_q    <= accept && win_done;
        last1_q <= accept && win_done && win_last;
        v2_q    <= v1_q;
        last2_q <= last1_q;
      end
    end
  end

  // Datapath: line buffers, window, products, sum
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < K - 1; j++) begin
        for (int n = 0; n < N; n++) begin
          lb_q[j][n] <= '0;
        end
      end
      for (int i = 0; i < KK; i++) begin
        win_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      y_q <= '0;
    end else begin
      if (accept) begin
        // Each buffer slot at this column ages by one row.
        lb_q[0][col_q] <= i_x;
        for (int j = 1; j < K - 1; j++) begin
          lb_q[j][col_q] <= lb_q[j-1][col_q];
        end
        for (int i = 0; i < KK; i++) begin
          win_q[i]  <= win_d[i];
          prod_q[i] <= prod_d[i];
        end
      end
      if (adv && v1_q) begin
        y_q <= y_d;
      end
    end
  end

  assign o_valid = v2_q && !rst;
  assign o_last  = v2_q && last2_q && !rst;
  assign o_y     = (v2_q && !rst) ? y_q : '0;

endmodule
